// File: rtl/decode_ibuf_pkg.sv
// Shared definitions for the instruction buffer: predecode bit layout, MIPS
// opcode/funct/rt encodings and the per-entry storage record.
package decode_ibuf_pkg;

   localparam int PD_W      = 10;
   localparam int PD_BRANCH = 0;
   localparam int PD_LINK   = 1;
   localparam int PD_JUMP   = 2;
   localparam int PD_JR     = 3;
   localparam int PD_LOAD   = 4;
   localparam int PD_STORE  = 5;
   localparam int PD_HILO   = 6;
   localparam int PD_CP0    = 7;
   localparam int PD_RI     = 8;
   localparam int PD_SYSBP  = 9;

   localparam logic [31:0] INST_ERET = 32'h4200_0018;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_REGIMM  = 6'h01;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_BLEZ    = 6'h06;
   localparam logic [5:0] OP_BGTZ    = 6'h07;
   localparam logic [5:0] OP_ADDI    = 6'h08;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_SLTI    = 6'h0A;
   localparam logic [5:0] OP_SLTIU   = 6'h0B;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_COP0    = 6'h10;
   localparam logic [5:0] OP_LB      = 6'h20;
   localparam logic [5:0] OP_LH      = 6'h21;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_LBU     = 6'h24;
   localparam logic [5:0] OP_LHU     = 6'h25;
   localparam logic [5:0] OP_SB      = 6'h28;
   localparam logic [5:0] OP_SH      = 6'h29;
   localparam logic [5:0] OP_SW      = 6'h2B;

   localparam logic [5:0] FN_SLL     = 6'h00;
   localparam logic [5:0] FN_SRL     = 6'h02;
   localparam logic [5:0] FN_SRA     = 6'h03;
   localparam logic [5:0] FN_SLLV    = 6'h04;
   localparam logic [5:0] FN_SRLV    = 6'h06;
   localparam logic [5:0] FN_SRAV    = 6'h07;
   localparam logic [5:0] FN_JR      = 6'h08;
   localparam logic [5:0] FN_JALR    = 6'h09;
   localparam logic [5:0] FN_SYSCALL = 6'h0C;
   localparam logic [5:0] FN_BREAK   = 6'h0D;
   localparam logic [5:0] FN_MFHI    = 6'h10;
   localparam logic [5:0] FN_MTHI    = 6'h11;
   localparam logic [5:0] FN_MFLO    = 6'h12;
   localparam logic [5:0] FN_MTLO    = 6'h13;
   localparam logic [5:0] FN_MULT    = 6'h18;
   localparam logic [5:0] FN_MULTU   = 6'h19;
   localparam logic [5:0] FN_DIV     = 6'h1A;
   localparam logic [5:0] FN_DIVU    = 6'h1B;
   localparam logic [5:0] FN_ADD     = 6'h20;
   localparam logic [5:0] FN_ADDU    = 6'h21;
   localparam logic [5:0] FN_SUB     = 6'h22;
   localparam logic [5:0] FN_SUBU    = 6'h23;
   localparam logic [5:0] FN_AND     = 6'h24;
   localparam logic [5:0] FN_OR      = 6'h25;
   localparam logic [5:0] FN_XOR     = 6'h26;
   localparam logic [5:0] FN_NOR     = 6'h27;
   localparam logic [5:0] FN_SLT     = 6'h2A;
   localparam logic [5:0] FN_SLTU    = 6'h2B;

   localparam logic [4:0] RT_BLTZ    = 5'h00;
   localparam logic [4:0] RT_BGEZ    = 5'h01;
   localparam logic [4:0] RT_BLTZAL  = 5'h10;
   localparam logic [4:0] RT_BGEZAL  = 5'h11;

   localparam logic [4:0] RS_MFC0    = 5'h00;
   localparam logic [4:0] RS_MTC0    = 5'h04;

   typedef struct packed {
      logic [31:0]     inst;
      logic [31:0]     pc;
      logic [PD_W-1:0] pd;
      logic            in_ds;
   } ibuf_entry_t;

   // Any control transfer opens a delay slot for the instruction after it.
   function automatic logic pd_ctl(input logic [PD_W-1:0] pd);
      return pd[PD_BRANCH] | pd[PD_JUMP] | pd[PD_JR];
   endfunction

endpackage

// File: rtl/decode_ibuf_predecode.sv
// Combinational predecoder: classifies one 32-bit instruction into the
// predecode vector; anything outside the supported set flags reserved-instruction.
module decode_ibuf_predecode
   import decode_ibuf_pkg::*;
(
   input  logic [31:0]     inst_i,
   output logic [PD_W-1:0] pd_o
);

   logic [5:0] opcode;
   logic [5:0] funct;
   logic [4:0] rs;
   logic [4:0] rt;
   logic       known;

   assign opcode = inst_i[31:26];
   assign rs     = inst_i[25:21];
   assign rt     = inst_i[20:16];
   assign funct  = inst_i[5:0];

   always_comb begin
      pd_o  = '0;
      known = 1'b0;
      case (opcode)
         OP_SPECIAL: begin
            case (funct)
               FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
               FN_MFHI, FN_MFLO, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
               FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: known = 1'b1;
               FN_JR: begin
                  known        = 1'b1;
                  pd_o[PD_JR]  = 1'b1;
               end
               FN_JALR: begin
                  known         = 1'b1;
                  pd_o[PD_JR]   = 1'b1;
                  pd_o[PD_LINK] = 1'b1;
               end
               FN_SYSCALL, FN_BREAK: begin
                  known          = 1'b1;
                  pd_o[PD_SYSBP] = 1'b1;
               end
               FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MTHI, FN_MTLO: begin
                  known         = 1'b1;
                  pd_o[PD_HILO] = 1'b1;
               end
               default: ;
            endcase
         end
         OP_REGIMM: begin
            case (rt)
               RT_BLTZ, RT_BGEZ: begin
                  known           = 1'b1;
                  pd_o[PD_BRANCH] = 1'b1;
               end
               RT_BLTZAL, RT_BGEZAL: begin
                  known           = 1'b1;
                  pd_o[PD_BRANCH] = 1'b1;
                  pd_o[PD_LINK]   = 1'b1;
               end
               default: ;
            endcase
         end
         OP_J: begin
            known         = 1'b1;
            pd_o[PD_JUMP] = 1'b1;
         end
         OP_JAL: begin
            known         = 1'b1;
            pd_o[PD_JUMP] = 1'b1;
            pd_o[PD_LINK] = 1'b1;
         end
         OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
            known           = 1'b1;
            pd_o[PD_BRANCH] = 1'b1;
         end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
         OP_ANDI, OP_ORI, OP_XORI, OP_LUI: known = 1'b1;
         OP_COP0: begin
            // ERET is matched on the full word; MFC0/MTC0 only on rs.
            if (inst_i == INST_ERET || rs == RS_MFC0 || rs == RS_MTC0) begin
               known        = 1'b1;
               pd_o[PD_CP0] = 1'b1;
            end
         end
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
            known         = 1'b1;
            pd_o[PD_LOAD] = 1'b1;
         end
         OP_SB, OP_SH, OP_SW: begin
            known          = 1'b1;
            pd_o[PD_STORE] = 1'b1;
         end
         default: ;
      endcase
      pd_o[PD_RI] = ~known;
   end

endmodule

// File: rtl/decode_ibuf.sv
// Instruction buffer between fetch and decode: multi-lane enqueue with
// predecode and delay-slot tagging, single-entry first-word-fall-through dequeue.
module decode_ibuf
   import decode_ibuf_pkg::*;
#(
   parameter  int DEPTH   = 8,
   parameter  int FETCH_W = 2,
   localparam int PTR_W   = $clog2(DEPTH),
   localparam int CNT_W   = PTR_W + 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   input  logic [FETCH_W-1:0]   in_valid_i,
   input  logic [32*FETCH_W-1:0] in_inst_i,
   input  logic [31:0]          in_pc_i,
   output logic                 in_ready_o,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [31:0]          out_inst_o,
   output logic [31:0]          out_pc_o,
   output logic [PD_W-1:0]      out_pd_o,
   output logic                 out_in_ds_o,
   output logic [CNT_W-1:0]     count_o
);

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ds_pending_q, ds_pending_d;

   ibuf_entry_t      mem_q [DEPTH];
   ibuf_entry_t      head_e;

   logic [PD_W-1:0]  lane_pd [FETCH_W];
   logic [FETCH_W-1:0] lane_ctl;
   logic [FETCH_W-1:0] lane_ds;
   logic [CNT_W-1:0] n_enq;
   logic             ds_last;
   logic             enq;
   logic             deq;

   for (genvar g = 0; g < FETCH_W; g++) begin : g_lane
      decode_ibuf_predecode u_predecode (
         .inst_i (in_inst_i[32*g +: 32]),
         .pd_o   (lane_pd[g])
      );
      assign lane_ctl[g] = pd_ctl(lane_pd[g]);
      if (g == 0) begin : g_first
         assign lane_ds[g] = ds_pending_q;
      end else begin : g_rest
         assign lane_ds[g] = lane_ctl[g-1];
      end
   end

   // Readiness looks only at registered occupancy so fetch never waits on decode.
   assign in_ready_o  = (count_q <= CNT_W'(DEPTH - FETCH_W));
   assign out_valid_o = (count_q != '0);
   assign enq         = in_ready_o & in_valid_i[0];
   assign deq         = out_valid_o & out_ready_i;

   always_comb begin
      n_enq   = '0;
      ds_last = ds_pending_q;
      for (int i = 0; i < FETCH_W; i++) begin
         if (in_valid_i[i]) begin
            n_enq   = n_enq + CNT_W'(1);
            ds_last = lane_ctl[i];
         end
      end
   end

   always_comb begin
      head_d       = head_q + PTR_W'(deq);
      tail_d       = enq ? tail_q + n_enq[PTR_W-1:0] : tail_q;
      count_d      = count_q + (enq ? n_enq : '0) - CNT_W'(deq);
      ds_pending_d = enq ? ds_last : ds_pending_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         ds_pending_q <= 1'b0;
      end else if (flush_i) begin
         // Collapse head onto tail so the next write lands where it is read.
         head_q       <= tail_q;
         count_q      <= '0;
         ds_pending_q <= 1'b0;
      end else begin
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         ds_pending_q <= ds_pending_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && !flush_i && enq) begin
         for (int i = 0; i < FETCH_W; i++) begin
            if (in_valid_i[i]) begin
               mem_q[tail_q + PTR_W'(i)] <= '{inst:  in_inst_i[32*i +: 32],
                                              pc:    in_pc_i + 32'(4 * i),
                                              pd:    lane_pd[i],
                                              in_ds: lane_ds[i]};
            end
         end
      end
   end

   assign head_e      = mem_q[head_q];
   assign out_inst_o  = out_valid_o ? head_e.inst  : '0;
   assign out_pc_o    = out_valid_o ? head_e.pc    : '0;
   assign out_pd_o    = out_valid_o ? head_e.pd    : '0;
   assign out_in_ds_o = out_valid_o ? head_e.in_ds : 1'b0;
   assign count_o     = count_q;

endmodule

// File: tb/tb_decode_ibuf.sv
// Self-checking bench for decode_ibuf: directed scenarios plus a randomized
// run against a queue-based reference model of the buffer.
module tb_decode_ibuf;

   localparam int DEPTH   = 8;
   localparam int FETCH_W = 2;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [9:0]  pd;
      logic        ds;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic [1:0]  in_valid = 2'b00;
   logic [63:0] in_inst = '0;
   logic [31:0] in_pc = '0;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic [9:0]  out_pd;
   logic        out_in_ds;
   logic [3:0]  count;

   int n_tests = 0;
   int n_fail  = 0;

   ent_t        m_q[$];
   logic        m_dsp = 1'b0;
   logic        m_enq;
   logic        m_deq;
   logic [9:0]  lane_pd [2];

   decode_ibuf #(.DEPTH(DEPTH), .FETCH_W(FETCH_W)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .flush_i     (flush),
      .in_valid_i  (in_valid),
      .in_inst_i   (in_inst),
      .in_pc_i     (in_pc),
      .in_ready_o  (in_ready),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_inst_o  (out_inst),
      .out_pc_o    (out_pc),
      .out_pd_o    (out_pd),
      .out_in_ds_o (out_in_ds),
      .count_o     (count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      assert (in_valid != 2'b10) else $error("in_valid lanes not contiguous");
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic ctl(input logic [9:0] pd);
      return pd[0] | pd[2] | pd[3];
   endfunction

   task automatic set_lanes(input logic [31:0] i0, input logic [9:0] p0,
                            input logic [31:0] i1, input logic [9:0] p1);
      in_inst    = {i1, i0};
      lane_pd[0] = p0;
      lane_pd[1] = p1;
   endtask

   // Advance one clock and apply the buffer's rules to the reference queue.
   task automatic tick();
      ent_t e;
      m_enq = !rst && !flush && in_valid[0] && (m_q.size() <= DEPTH - FETCH_W);
      m_deq = !rst && !flush && out_ready && (m_q.size() != 0);
      @(posedge clk);
      #1;
      if (rst || flush) begin
         m_q.delete();
         m_dsp = 1'b0;
      end else begin
         if (m_deq) m_q.delete(0);
         if (m_enq) begin
            e.inst = in_inst[31:0];
            e.pc   = in_pc;
            e.pd   = lane_pd[0];
            e.ds   = m_dsp;
            m_q.push_back(e);
            m_dsp  = ctl(lane_pd[0]);
            if (in_valid[1]) begin
               e.inst = in_inst[63:32];
               e.pc   = in_pc + 32'd4;
               e.pd   = lane_pd[1];
               e.ds   = ctl(lane_pd[0]);
               m_q.push_back(e);
               m_dsp  = ctl(lane_pd[1]);
            end
         end
      end
   endtask

   task automatic clear();
      flush    = 1'b1;
      in_valid = 2'b00;
      tick();
      flush    = 1'b0;
   endtask

   // Random instruction drawn from known classes, with its expected predecode.
   task automatic gen_inst(output logic [31:0] inst, output logic [9:0] pd);
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 14))
         0:  begin inst = {6'h09, r[25:0]};                          pd = 10'h000; end
         1:  begin inst = {6'h04, r[25:0]};                          pd = 10'h001; end
         2:  begin inst = {6'h02, r[25:0]};                          pd = 10'h004; end
         3:  begin inst = {6'h03, r[25:0]};                          pd = 10'h006; end
         4:  begin inst = {6'h00, r[25:21], 15'h0, 6'h08};           pd = 10'h008; end
         5:  begin inst = {6'h00, r[25:21], 5'h0, r[15:11], 5'h0, 6'h09}; pd = 10'h00A; end
         6:  begin inst = {6'h23, r[25:0]};                          pd = 10'h010; end
         7:  begin inst = {6'h2B, r[25:0]};                          pd = 10'h020; end
         8:  begin inst = {6'h00, r[25:16], 10'h0, 6'h18};           pd = 10'h040; end
         9:  begin inst = {6'h10, 5'h04, r[20:11], 8'h0, r[2:0]};    pd = 10'h080; end
         10: begin inst = 32'h4200_0018;                             pd = 10'h080; end
         11: begin inst = {6'h00, r[25:6], 6'h0C};                   pd = 10'h200; end
         12: begin inst = {6'h3F, r[25:0]};                          pd = 10'h100; end
         13: begin inst = {6'h01, r[25:21], 5'h10, r[15:0]};         pd = 10'h003; end
         default: begin inst = {6'h00, r[25:11], 5'h0, 6'h21};      pd = 10'h000; end
      endcase
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; in_valid = 2'b00; out_ready = 1'b1;
      tick(); tick();
      rst = 1'b0;
      n_tests++; if (count !== 4'd0)      begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
      n_tests++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      n_tests++; if (out_inst !== 32'h0)  begin n_fail++; $display("FAIL reset_out_inst got %h exp 0", out_inst); end
      n_tests++; if (out_pc !== 32'h0)    begin n_fail++; $display("FAIL reset_out_pc got %h exp 0", out_pc); end
      n_tests++; if (out_pd !== 10'h0)    begin n_fail++; $display("FAIL reset_out_pd got %h exp 0", out_pd); end
      n_tests++; if (out_in_ds !== 1'b0)  begin n_fail++; $display("FAIL reset_out_in_ds got %b exp 0", out_in_ds); end
      n_tests++; if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      tick();
      n_tests++; if (count !== 4'd0)      begin n_fail++; $display("FAIL empty_no_underflow got %0d exp 0", count); end
      out_ready = 1'b0;
   endtask

   task automatic test_single_bundle();
      set_lanes(32'h2402_0005, 10'h000, 32'h1000_FFFF, 10'h001);
      in_pc = 32'hBFC0_0000; in_valid = 2'b11; out_ready = 1'b0;
      tick();
      in_valid = 2'b00;
      n_tests++; if (out_valid !== 1'b1)       begin n_fail++; $display("FAIL single_valid got %b exp 1", out_valid); end
      n_tests++; if (out_pc !== 32'hBFC0_0000) begin n_fail++; $display("FAIL single_pc0 got %h exp bfc00000", out_pc); end
      n_tests++; if (out_inst !== 32'h2402_0005) begin n_fail++; $display("FAIL single_inst0 got %h exp 24020005", out_inst); end
      n_tests++; if (out_pd !== 10'h000)       begin n_fail++; $display("FAIL single_pd0 got %h exp 000", out_pd); end
      n_tests++; if (count !== 4'd2)           begin n_fail++; $display("FAIL single_count got %0d exp 2", count); end
      out_ready = 1'b1;
      tick();
      n_tests++; if (out_pc !== 32'hBFC0_0004) begin n_fail++; $display("FAIL single_pc1 got %h exp bfc00004", out_pc); end
      n_tests++; if (out_pd !== 10'h001)       begin n_fail++; $display("FAIL single_pd1 got %h exp 001", out_pd); end
      n_tests++; if (out_in_ds !== 1'b0)       begin n_fail++; $display("FAIL single_ds1 got %b exp 0", out_in_ds); end
      tick();
      n_tests++; if (count !== 4'd0)           begin n_fail++; $display("FAIL single_drain got %0d exp 0", count); end
      out_ready = 1'b0;
      clear();
   endtask

   task automatic test_cross_ds();
      logic [31:0] exp_inst [4];
      logic        exp_ds   [4];
      exp_inst = '{32'h0, 32'h0800_0040, 32'h0, 32'h0};
      exp_ds   = '{1'b0, 1'b0, 1'b1, 1'b0};
      set_lanes(32'h0, 10'h000, 32'h0800_0040, 10'h004);
      in_pc = 32'h0000_0100; in_valid = 2'b11;
      tick();
      set_lanes(32'h0, 10'h000, 32'h0, 10'h000);
      in_pc = 32'h0000_0108;
      tick();
      in_valid = 2'b00; out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         n_tests++;
         if ({out_valid, out_inst, out_in_ds} !== {1'b1, exp_inst[k], exp_ds[k]}) begin
            n_fail++;
            $display("FAIL cross_ds_entry%0d got v=%b inst=%h ds=%b exp v=1 inst=%h ds=%b",
                     k, out_valid, out_inst, out_in_ds, exp_inst[k], exp_ds[k]);
         end
         tick();
      end
      out_ready = 1'b0;
      clear();
   endtask

   task automatic test_fill();
      out_ready = 1'b0; in_pc = 32'h0000_2000;
      for (int b = 0; b < 5; b++) begin
         set_lanes(32'h2402_0000 | 32'(2*b), 10'h000, 32'h2402_0000 | 32'(2*b+1), 10'h000);
         in_valid = 2'b11;
         n_tests++;
         if (in_ready !== (b < 4)) begin
            n_fail++; $display("FAIL fill_in_ready_b%0d got %b exp %b", b, in_ready, b < 4);
         end
         tick();
         in_pc = in_pc + 32'd8;
      end
      in_valid = 2'b00;
      n_tests++; if (count !== 4'd8) begin n_fail++; $display("FAIL fill_full_count got %0d exp 8", count); end
      out_ready = 1'b1;
      tick(); tick();
      out_ready = 1'b0;
      n_tests++; if (count !== 4'd6 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL fill_at6 got count=%0d rdy=%b exp count=6 rdy=1", count, in_ready);
      end
      set_lanes(32'h2402_0100, 10'h000, 32'h1000_0003, 10'h001);
      in_valid = 2'b11; out_ready = 1'b1;
      tick();
      in_valid = 2'b00; out_ready = 1'b0;
      n_tests++; if (count !== 4'd7 || in_ready !== 1'b0) begin
         n_fail++; $display("FAIL fill_enq_deq got count=%0d rdy=%b exp count=7 rdy=0", count, in_ready);
      end
      set_lanes(32'h2402_0200, 10'h000, 32'h2402_0201, 10'h000);
      in_valid = 2'b01;
      tick();
      in_valid = 2'b00;
      n_tests++; if (count !== 4'd7) begin n_fail++; $display("FAIL fill_ignored_at7 got %0d exp 7", count); end
      out_ready = 1'b1;
      for (int c = 0; c < 12 && m_q.size() != 0; c++) begin
         n_tests++;
         if ({out_valid, out_inst, out_pc, out_pd, out_in_ds} !==
             {1'b1, m_q[0].inst, m_q[0].pc, m_q[0].pd, m_q[0].ds}) begin
            n_fail++;
            $display("FAIL fill_drain%0d got %h/%h/%h/%b exp %h/%h/%h/%b", c,
                     out_inst, out_pc, out_pd, out_in_ds, m_q[0].inst, m_q[0].pc, m_q[0].pd, m_q[0].ds);
         end
         tick();
      end
      out_ready = 1'b0;
      clear();
   endtask

   task automatic test_flush();
      set_lanes(32'h0, 10'h000, 32'h0800_0040, 10'h004);
      in_pc = 32'h0000_0300; in_valid = 2'b11;
      tick();
      set_lanes(32'h0800_0050, 10'h004, 32'h0800_0060, 10'h004);
      flush = 1'b1; out_ready = 1'b1;
      tick();
      flush = 1'b0; in_valid = 2'b00; out_ready = 1'b0;
      n_tests++; if (count !== 4'd0)     begin n_fail++; $display("FAIL flush_count got %0d exp 0", count); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got %b exp 0", out_valid); end
      set_lanes(32'h0, 10'h000, 32'h0, 10'h000);
      in_pc = 32'h0000_0400; in_valid = 2'b01;
      tick();
      in_valid = 2'b00;
      n_tests++; if ({out_valid, out_in_ds, count} !== {1'b1, 1'b0, 4'd1}) begin
         n_fail++; $display("FAIL flush_next_nop got v=%b ds=%b cnt=%0d exp v=1 ds=0 cnt=1",
                            out_valid, out_in_ds, count);
      end
      clear();
   endtask

   task automatic test_classify();
      logic [31:0] ci [4];
      logic [9:0]  cp [4];
      ci = '{32'h0000_000C, 32'h4200_0018, 32'hFC00_0000, 32'h0000_0008};
      cp = '{10'h200, 10'h080, 10'h100, 10'h008};
      for (int k = 0; k < 4; k++) begin
         set_lanes(ci[k], cp[k], 32'h0, 10'h000);
         in_pc = 32'h0000_1000; in_valid = 2'b01;
         tick();
         in_valid = 2'b00;
         n_tests++;
         if (out_pd !== cp[k]) begin
            n_fail++; $display("FAIL classify_%h got %h exp %h", ci[k], out_pd, cp[k]);
         end
         clear();
      end
   endtask

   task automatic test_wrap_random();
      logic [31:0] i0, i1;
      logic [9:0]  p0, p1;
      ent_t        h;
      int          b;
      bit          have;
      b = 0; have = 1'b0;
      for (int c = 0; c < 400 && !(b == 20 && m_q.size() == 0); c++) begin
         if (b < 20 && !have) begin
            gen_inst(i0, p0); gen_inst(i1, p1);
            set_lanes(i0, p0, i1, p1);
            in_pc    = $urandom & 32'hFFFF_FFFC;
            in_valid = ($urandom_range(0, 2) == 0) ? 2'b01 : 2'b11;
            have     = 1'b1;
         end
         if (b == 20) in_valid = 2'b00;
         out_ready = (b == 20) ? 1'b1 : 1'($urandom_range(0, 1));
         if (m_q.size() != 0) h = m_q[0];
         else begin h.inst = '0; h.pc = '0; h.pd = '0; h.ds = 1'b0; end
         n_tests++;
         if ({count, in_ready, out_valid} !==
             {4'(m_q.size()), m_q.size() <= DEPTH - FETCH_W, m_q.size() != 0}) begin
            n_fail++;
            $display("FAIL wrap_status_c%0d got cnt=%0d rdy=%b v=%b exp cnt=%0d", c,
                     count, in_ready, out_valid, m_q.size());
         end
         n_tests++;
         if ({out_inst, out_pc, out_pd, out_in_ds} !== {h.inst, h.pc, h.pd, h.ds}) begin
            n_fail++;
            $display("FAIL wrap_head_c%0d got %h/%h/%h/%b exp %h/%h/%h/%b", c,
                     out_inst, out_pc, out_pd, out_in_ds, h.inst, h.pc, h.pd, h.ds);
         end
         tick();
         if (have && m_enq) begin
            have = 1'b0;
            b++;
         end
      end
      in_valid = 2'b00; out_ready = 1'b0;
      n_tests++;
      if (b != 20 || m_q.size() != 0 || count !== 4'd0) begin
         n_fail++; $display("FAIL wrap_completion got bundles=%0d cnt=%0d exp bundles=20 cnt=0", b, count);
      end
   endtask

   initial begin
      lane_pd[0] = '0;
      lane_pd[1] = '0;
      test_reset();
      test_single_bundle();
      test_cross_ds();
      test_fill();
      test_flush();
      test_classify();
      test_wrap_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
